// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings the core PLL out of reset, waits for a lock that stays up long
// enough to trust, then releases the per-domain resets one stage at a time.
// The block runs from the free-running PLL reference clock, so it keeps
// working while the PLL outputs are stopped or unstable.
//
// State flow:
//   PLL_RST   -> WAIT_LOCK  after RST_CYCLES cycles with pll_rst high
//   WAIT_LOCK -> STABLE     as soon as synchronized lock is seen
//   WAIT_LOCK -> PLL_RST    after LOCK_TIMEOUT cycles without lock (retry_cnt++)
//   STABLE    -> WAIT_LOCK  on any lock drop (stable count restarts)
//   STABLE    -> RELEASE    after STABLE_CYCLES consecutive locked cycles
//   RELEASE   -> RUN        once every stage is released and one more gap passes
//   RELEASE/RUN -> WAIT_LOCK on lock drop (lock_loss_cnt++)
//   any       -> PLL_RST    on force_reset (wins over everything else)
//
// Every output is a flop loaded from the next-state decode, so no input
// reaches an output through combinational logic. dbg_state mirrors the
// FSM register for observation.
//
// reset_out deassertion is not synchronized to the destination domains;
// each destination must do that locally.

module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_GAP     = 64,
    parameter int CNT_W         = 8
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  force_reset,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  ready,
    output logic [CNT_W-1:0]      retry_cnt,
    output logic [CNT_W-1:0]      lock_loss_cnt,
    output logic [2:0]            dbg_state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RELEASE   = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;

    // ------------------------------------------------------------------
    // Timer sizing: one timer serves every timed state, so it must hold
    // the largest terminal count of any of them.
    // ------------------------------------------------------------------
    localparam int REL_CYCLES = NUM_STAGES * STAGE_GAP;
    localparam int MAX_A      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B      = (STABLE_CYCLES > REL_CYCLES) ? STABLE_CYCLES : REL_CYCLES;
    localparam int TMR_MAXV   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W      = $clog2(TMR_MAXV + 1);

    // Terminal counts. The timer reads 0 in the first cycle of a state, so
    // a state lasting N cycles ends when the timer reads N-1.
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    // Stage i drops at the edge where the timer goes to i*STAGE_GAP+1.
    // The last stage drops at (NUM_STAGES-1)*STAGE_GAP+1; RUN follows
    // STAGE_GAP edges later, i.e. when the timer reads NUM_STAGES*STAGE_GAP.
    localparam logic [TMR_W-1:0] REL_LAST = TMR_W'(REL_CYCLES);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TMR_MAXV);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                  r_sync1;
    logic                  r_sync2;
    logic [2:0]            r_state;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_pll_rst;
    logic [NUM_STAGES-1:0] r_reset_out;
    logic                  r_ready;
    logic [CNT_W-1:0]      r_retry_cnt;
    logic [CNT_W-1:0]      r_lock_loss_cnt;

    // ------------------------------------------------------------------
    // Next-state / next-output wires
    // ------------------------------------------------------------------
    logic                  w_locked_s;
    logic [2:0]            w_state_nxt;
    logic                  w_retry_inc;
    logic                  w_loss_inc;
    logic                  w_timer_clr;
    logic [TMR_W-1:0]      w_timer_nxt;
    logic                  w_pll_rst_nxt;
    logic [NUM_STAGES-1:0] w_reset_out_nxt;
    logic                  w_ready_nxt;

    assign w_locked_s = r_sync2;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state decode; force_reset overrides every other transition,
    // including a coincident lock loss, so no counter moves on a force.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
        if (force_reset) begin
            w_state_nxt = ST_PLL_RST;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_timer == RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_timer == TO_LAST) begin
                        w_state_nxt = ST_PLL_RST;
                        w_retry_inc = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                    end else if (r_timer == STB_LAST) begin
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_loss_inc  = 1'b1;
                    end else if (r_timer == REL_LAST) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_loss_inc  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_PLL_RST;
                end
            endcase
        end
    end

    // Shared timer: cleared on every state entry and on a force (which also
    // restarts PLL_RST when already there); otherwise counts and saturates.
    always_comb begin
        w_timer_clr = force_reset || (w_state_nxt != r_state);
        if (w_timer_clr) begin
            w_timer_nxt = '0;
        end else if (r_timer == TMR_MAX) begin
            w_timer_nxt = r_timer;
        end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
        end
    end

    // Output decode from the next state and next timer value, so the output
    // flops change on the same edge as the state register.
    always_comb begin
        w_pll_rst_nxt   = (w_state_nxt == ST_PLL_RST);
        w_ready_nxt     = (w_state_nxt == ST_RUN);
        w_reset_out_nxt = '1;
        if (w_state_nxt == ST_RUN) begin
            w_reset_out_nxt = '0;
        end else if (w_state_nxt == ST_RELEASE) begin
            // Stage i stays asserted while the timer is at or below
            // i*STAGE_GAP; a threshold compare keeps the release order
            // monotonic (lower stages always drop first).
            for (int i = 0; i < NUM_STAGES; i++) begin
                w_reset_out_nxt[i] = (w_timer_nxt <= TMR_W'(i * STAGE_GAP));
            end
        end
    end

    // FSM state and shared timer.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_PLL_RST;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Registered outputs toward the PLL and the clock domains.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst   <= 1'b1;
            r_reset_out <= '1;
            r_ready     <= 1'b0;
        end else begin
            r_pll_rst   <= w_pll_rst_nxt;
            r_reset_out <= w_reset_out_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    // Saturating status counters for lock timeouts and lock drops.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry_cnt     <= '0;
            r_lock_loss_cnt <= '0;
        end else begin
            if (w_retry_inc && (r_retry_cnt != CNT_MAX)) begin
                r_retry_cnt <= r_retry_cnt + CNT_W'(1);
            end
            if (w_loss_inc && (r_lock_loss_cnt != CNT_MAX)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + CNT_W'(1);
            end
        end
    end

    assign pll_rst       = r_pll_rst;
    assign reset_out     = r_reset_out;
    assign ready         = r_ready;
    assign retry_cnt     = r_retry_cnt;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign dbg_state     = r_state;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the core PLL and also feeds it back its reset.
- Consumes the PLL's asynchronous locked output and drives the PLL's active-high reset input.
- Holds the core's clock domains in reset until lock is proven stable, then releases per-domain resets in a fixed order and reports readiness.
- Runs on the free-running 50 MHz PLL reference clock, so it keeps operating when the PLL outputs stop.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive locked cycles required before release
NUM_STAGES, 3, number of staged reset outputs
STAGE_GAP, 64, cycles between successive stage releases (>=1)
CNT_W, 8, width of saturating status counters

Ports:
refclk  in  1  50 MHz free-running clock, the PLL reference clock
rst_n  in  1  asynchronous active-low reset
locked  in  1  PLL lock, asynchronous to refclk
force_reset  in  1  synchronous one-cycle request to restart the PLL
pll_rst  out  1  active-high reset to PLL
reset_out  out  NUM_STAGES  active-high domain resets; bit 0 released first
ready  out  1  high when all stages are released and lock is held
retry_cnt  out  CNT_W  saturating count of lock timeouts
lock_loss_cnt  out  CNT_W  saturating count of lock drops after release

Behaviour:
- Interface: one clock, refclk. Reset rst_n is asynchronous and active-low.
- locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). All decisions use locked_s.
- On rst_n low (async):
  - state = PLL_RST, pll_rst = 1, reset_out = all ones, ready = 0.
  - Both counters = 0; internal timer = 0; synchronizer flops = 0.
- A single timer clears on every state entry.
- States:
  - PLL_RST: pll_rst = 1, reset_out = all ones. After exactly RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst = 0, reset_out = all ones.
    - If locked_s = 1, go to STABLE.
    - Otherwise, after LOCK_TIMEOUT cycles without lock, go to PLL_RST and increment retry_cnt (saturating).
  - STABLE: reset_out = all ones.
    - If locked_s = 0, go to WAIT_LOCK with no count increment.
    - After STABLE_CYCLES consecutive locked cycles, go to RELEASE.
  - RELEASE:
    - reset_out[i] deasserts at the edge i*STAGE_GAP cycles after RELEASE entry, i.e. bit 0 at the entry edge + 1.
    - After the last stage deasserts plus STAGE_GAP cycles, go to RUN.
  - RUN: ready = 1, reset_out = 0. Monitor lock.
- Lock loss in RELEASE or RUN (locked_s = 0):
  - Next edge: reset_out = all ones and ready = 0, both registered.
  - lock_loss_cnt increments (saturating); go to WAIT_LOCK.
  - No PLL reset is issued; the timeout path handles retry.
- force_reset = 1 in any state, next edge:
  - Go to PLL_RST; pll_rst = 1, reset_out = all ones, ready = 0.
  - Overrides a simultaneous lock loss; lock_loss_cnt does not increment.
  - force_reset while already in PLL_RST restarts the RST_CYCLES count.
- Saturation: counters stick at 2^CNT_W-1 and do not wrap.
- Ordering invariants:
  - reset_out[j] is never 0 while reset_out[i] is 1 for i<j.
  - ready is 1 only when reset_out == 0.
- All outputs are registered with no combinational paths from inputs.
- Destination domains must synchronize reset_out deassertion locally; this block does not do it.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=2, CNT_W=4 for all scenarios.
1. Nominal bring-up: rst_n released, locked rises 3 cycles after pll_rst falls.
   - pll_rst high exactly 4 cycles.
   - reset_out goes 111 -> 110 -> 100 -> 000 at 2-cycle spacing, after 8 stable cycles plus 2 synchronizer cycles.
   - ready=1 two cycles after 000; both counters = 0.
2. Lock timeout: locked held 0.
   - pll_rst pulses 4 cycles high, then stays low for 20 cycles, repeating.
   - retry_cnt increments once per cycle of this pattern and saturates at 15 after 15+ timeouts.
3. Glitch in STABLE: locked drops for 1 cycle after 5 stable cycles.
   - Returns to WAIT_LOCK; the stable count restarts from 0.
   - No counter changes; release is delayed accordingly.
4. Loss in RUN: locked falls while ready=1.
   - reset_out=111 and ready=0 within 3 edges of the falling edge (2 synchronizer + 1 registered).
   - lock_loss_cnt=1; full re-release follows when lock returns.
5. force_reset coincident with lock loss in RUN.
   - Next state PLL_RST, pll_rst=1, lock_loss_cnt unchanged.
6. rst_n asserted mid-RELEASE with reset_out=100.
   - All outputs immediately return to reset values (pll_rst=1, reset_out=111, ready=0, counters 0) without waiting for a clock edge.
